// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  // Controller states: waiting for a request, or shifting one bit per clock.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;  // digits at or above this get corrected
  localparam logic [3:0] ADD3_VAL    = 4'd3;  // correction added before each shift
  localparam logic [3:0] BLANK_CODE  = 4'hF;  // non-decimal code, decoders show it dark
  localparam logic [3:0] SAT_DIGIT   = 4'd9;  // digit value used for a saturated result

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Single-digit double-dabble correction: a digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decimal digit.
import bin_to_bcd_pkg::*;

module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Conditional add-3, 4-bit wrap is never reached for digits 0..9.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADD3_THRESH) begin
      o_digit = i_digit + ADD3_VAL;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a start/busy/done handshake. Values that do not fit in DIGITS decimal
// digits saturate to all nines and raise overflow.
// Optional build macro LEADING_BLANK_EN: digits above the most significant
// nonzero digit are replaced by the blank code at done (digit 0 and saturated
// results are never blanked).
import bin_to_bcd_pkg::*;

module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int TOT_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [TOT_W-1:0]   r_shift;
  logic [TOT_W-1:0]   w_shift_next;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic               r_ovf;
  logic               w_ovf_next;
  logic               r_done;
  logic               w_done_next;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_bcd_next;
  logic               r_overflow;
  logic               w_overflow_next;

  logic [TOT_W-1:0]   w_adj;
  logic [TOT_W-1:0]   w_shifted;
  logic [BCD_W-1:0]   w_digits;
  logic [BCD_W-1:0]   w_result;
  logic               w_out_bit;
  logic               w_ovf_final;
  logic               w_last;
  logic               w_lead;

  // Correct every digit of the BCD field; the binary field passes through.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_shift[BIN_W + 4*gi +: 4]),
        .o_digit (w_adj[BIN_W + 4*gi +: 4])
      );
    end
  endgenerate

  assign w_adj[BIN_W-1:0] = r_shift[BIN_W-1:0];

  // The bit leaving the top digit is lost precision, so it marks overflow.
  assign w_out_bit   = w_adj[TOT_W-1];
  assign w_shifted   = {w_adj[TOT_W-2:0], 1'b0};
  assign w_digits    = w_shifted[TOT_W-1:BIN_W];
  assign w_ovf_final = r_ovf | w_out_bit;
  assign w_last      = (r_count == LAST_CNT);

  // Final formatting of the digit field: saturation, then optional blanking.
  always_comb begin
    w_result = w_digits;
    w_lead   = 1'b1;
    if (w_ovf_final) begin
      for (int i = 0; i < DIGITS; i++) begin
        w_result[4*i +: 4] = SAT_DIGIT;
      end
    end
`ifdef LEADING_BLANK_EN
    else begin
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (w_lead && (w_digits[4*i +: 4] == 4'd0)) begin
          w_result[4*i +: 4] = BLANK_CODE;
        end else begin
          w_lead = 1'b0;
        end
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath-next logic for the conversion sequencer.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_count_next    = r_count;
    w_ovf_next      = r_ovf;
    w_done_next     = 1'b0;
    w_bcd_next      = r_bcd;
    w_overflow_next = r_overflow;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_shift_next = {{BCD_W{1'b0}}, bin};
          w_count_next = '0;
          w_ovf_next   = 1'b0;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_shift_next = w_shifted;
        w_count_next = r_count + 1'b1;
        w_ovf_next   = w_ovf_final;
        if (w_last) begin
          w_bcd_next      = w_result;
          w_overflow_next = w_ovf_final;
          w_done_next     = 1'b1;
          w_state_next    = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath and result registers; reset aborts any conversion in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift    <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_shift    <= w_shift_next;
      r_count    <= w_count_next;
      r_ovf      <= w_ovf_next;
      r_done     <= w_done_next;
      r_bcd      <= w_bcd_next;
      r_overflow <= w_overflow_next;
    end
  end

  assign busy     = (r_state == SHIFT);
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance,
// directed cases plus random values against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [15:0] bin_a, bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [19:0] bcd_a;
  logic [15:0] bcd_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut_a (
    .clock    (clock),
    .reset    (reset),
    .start    (start_a),
    .bin      (bin_a),
    .busy     (busy_a),
    .done     (done_a),
    .bcd      (bcd_a),
    .overflow (ovf_a)
  );

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut_b (
    .clock    (clock),
    .reset    (reset),
    .start    (start_b),
    .bin      (bin_b),
    .busy     (busy_b),
    .done     (done_b),
    .bcd      (bcd_b),
    .overflow (ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Decimal reference: digits by division, saturation by range comparison.
  function automatic logic [19:0] model(input int v, input int d, output logic ovf);
    int lim;
    int t;
    logic [19:0] r;
    lim = 1;
    r   = '0;
    for (int i = 0; i < d; i++) lim = lim * 10;
    lim = lim - 1;
    if (v > lim) begin
      ovf = 1'b1;
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'd9;
      return r;
    end
    ovf = 1'b0;
    t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef LEADING_BLANK_EN
    for (int i = d - 1; i > 0; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  function automatic logic obs_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic obs_done(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction

  function automatic logic obs_ovf(input int sel);
    return (sel == 0) ? ovf_a : ovf_b;
  endfunction

  function automatic logic [19:0] obs_bcd(input int sel);
    return (sel == 0) ? bcd_a : {4'h0, bcd_b};
  endfunction

  task automatic set_in(input int sel, input logic s, input logic [15:0] v);
    if (sel == 0) begin
      start_a = s;
      bin_a   = v;
    end else begin
      start_b = s;
      bin_b   = v;
    end
  endtask

  // One conversion: accept, count busy cycles, wait (bounded) for done, compare.
  // inject_at >= 0 pulses a second start with another value while busy.
  task automatic run(input int sel, input logic [15:0] v, input int inject_at);
    int cyc;
    int bsy;
    bit seen;
    logic [19:0] exp_bcd;
    logic exp_ovf;
    cyc  = 0;
    bsy  = 0;
    seen = 1'b0;
    exp_bcd = model(int'(v), (sel == 0) ? 5 : 4, exp_ovf);
    set_in(sel, 1'b1, v);
    step();
    set_in(sel, 1'b0, 16'($urandom));
    check("done_low_after_accept", 32'(obs_done(sel)), 32'd0);
    while (cyc < 40 && !seen) begin
      if (obs_busy(sel)) bsy++;
      if (cyc == inject_at) set_in(sel, 1'b1, 16'd7);
      step();
      cyc++;
      if (cyc == inject_at + 1) set_in(sel, 1'b0, 16'd7);
      seen = obs_done(sel);
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'd16);
    check("busy_cycles", 32'(bsy), 32'd16);
    check("busy_at_done", 32'(obs_busy(sel)), 32'd0);
    check("bcd", 32'(obs_bcd(sel)), 32'(exp_bcd));
    check("overflow", 32'(obs_ovf(sel)), 32'(exp_ovf));
    $display("conv dut=%0d bin=%0d bcd=%h ovf=%0d exp_bcd=%h exp_ovf=%0d lat=%0d",
             sel, v, obs_bcd(sel), obs_ovf(sel), exp_bcd, exp_ovf, cyc);
  endtask

  // Confirm no stray done pulse and an idle handshake for n cycles.
  task automatic idle_check(input int sel, input int n);
    int d;
    int b;
    d = 0;
    b = 0;
    repeat (n) begin
      step();
      if (obs_done(sel)) d++;
      if (obs_busy(sel)) b++;
    end
    check("no_extra_done", 32'(d), 32'd0);
    check("no_stray_busy", 32'(b), 32'd0);
  endtask

  initial begin
    logic [15:0] rv;
    reset = 1'b1;
    set_in(0, 1'b0, 16'd0);
    set_in(1, 1'b0, 16'd0);
    repeat (3) step();
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_bcd_a", 32'(bcd_a), 32'd0);
    check("rst_ovf_a", 32'(ovf_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_bcd_b", 32'(bcd_b), 32'd0);
    reset = 1'b0;
    step();

    // Zero, full-scale, then a start accepted in the done cycle.
    run(0, 16'd0, -1);
    run(0, 16'd65535, -1);
    run(0, 16'd1234, -1);
    step();
    check("done_one_cycle", 32'(done_a), 32'd0);

    // Four-digit instance: saturation, then the largest fitting value.
    run(1, 16'd12345, -1);
    run(1, 16'd9999, -1);
    run(1, 16'd10000, -1);
    step();

    // Start during busy is ignored.
    run(0, 16'd42, 5);
    idle_check(0, 20);

    // Reset at cycle 8 of a conversion aborts it.
    set_in(0, 1'b1, 16'd4321);
    step();
    set_in(0, 1'b0, 16'd0);
    repeat (7) step();
    check("busy_before_abort", 32'(busy_a), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_bcd", 32'(bcd_a), 32'd0);
    check("abort_ovf", 32'(ovf_a), 32'd0);
    idle_check(0, 25);
    run(0, 16'd555, -1);

    // Leading-digit cases.
    run(0, 16'd100, -1);
    run(0, 16'd0, -1);
    run(0, 16'd9, -1);

    // Random values on both widths.
    repeat (12) begin
      run(0, 16'($urandom_range(0, 65535)), -1);
      if ($urandom_range(0, 1) == 1) step();
    end
    repeat (12) begin
      if ($urandom_range(0, 1) == 1) rv = 16'($urandom_range(9990, 10010));
      else rv = 16'($urandom_range(0, 65535));
      run(1, rv, -1);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
